reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of entries (power of two, >=2).
REQ-002 SHALL have parameter TAG_W, default 3, equal to log2(DEPTH).
REQ-003 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-004 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have port disp_valid, input, 1, renamed instruction offered this cycle.
REQ-006 SHALL have port disp_ready, output, 1, entry available; combinational.
REQ-007 SHALL have port disp_has_dst, input, 1, instruction writes a register.
REQ-008 SHALL have port disp_areg, input, 3, architectural destination.
REQ-009 SHALL have port disp_preg, input, 4, newly allocated physical destination.
REQ-010 SHALL have port disp_old_preg, input, 4, previous mapping of disp_areg, freed at retire.
REQ-011 SHALL have port disp_tag, output, TAG_W, tail index the offered instruction receives; combinational.
REQ-012 SHALL have port cmpl_valid, input, 1, execution-complete strobe.
REQ-013 SHALL have port cmpl_tag, input, TAG_W, tag of completing instruction.
REQ-014 SHALL have port retire_out, output, 5, {old_preg[3:0], valid}; bit-compatible with the renamer free port.
REQ-015 SHALL have port commit_valid, output, 1, one instruction retired; registered.
REQ-016 SHALL have port commit_areg, output, 3, retired architectural destination; registered.
REQ-017 SHALL have port commit_preg, output, 4, retired physical destination; registered.
REQ-018 SHALL have port count, output, TAG_W+1, occupied entries; registered.

Function
REQ-019 SHALL be a circular buffer with head and tail pointers of TAG_W+1 bits (wrap bit); index = low TAG_W bits.
REQ-020 SHALL hold per entry: busy, done, has_dst, areg, preg, old_preg.
REQ-021 SHALL drive disp_ready = !rst && (count < DEPTH); a full ROB blocks dispatch even if a retire occurs in the same cycle.
REQ-022 SHALL accept dispatch on a rising edge with disp_valid && disp_ready: write entry at tail with busy=1, done=0, then tail+1.
REQ-023 SHALL ignore disp_valid when disp_ready=0; no state change.
REQ-024 SHALL set done on cmpl_valid when entry[cmpl_tag].busy=1; completion of a non-busy entry, or of an already-done entry, is ignored.
REQ-025 SHALL retire at most one entry per cycle: on an edge where head entry busy && done (registered state), clear busy, head+1.
REQ-026 SHALL register, on a retiring edge, commit_valid=1, commit_areg/commit_preg from the entry, and retire_out={old_preg, has_dst}; on a non-retiring edge commit_valid=0 and retire_out=5'b0.
REQ-027 SHALL hold commit_valid and retire_out[0] high for exactly one cycle per retired instruction.
REQ-028 SHALL give a minimum latency: dispatch at edge E0, complete at E1, retire outputs valid after E2.
REQ-029 SHALL update count by +1 for dispatch only, -1 for retire only, and 0 for both or neither.
REQ-030 SHALL, for a completion in the same cycle as head retirement, ignore the completion (entry already done).
REQ-031 SHALL retire strictly in dispatch order; out-of-order completions wait until they reach the head.
REQ-032 SHALL wrap pointers modulo 2*DEPTH; full = indices equal and wrap bits differ; empty = pointers equal.

Reset
REQ-033 SHALL, on an edge with rst=1, clear head, tail, count and all busy/done bits, and set commit_valid=0, commit_areg=0, commit_preg=0 and retire_out=0; all inputs are ignored that edge.
REQ-034 SHALL, on reset mid-operation, drop in-flight entries with no retire_out pulse.

Verification
REQ-035 SHALL cover: dispatch areg=2, preg=9, old=2, has_dst=1 at E0; complete tag 0 at E1 -> after E2 retire_out=5'b00101, commit_areg=2, commit_preg=9; count 1->0.
REQ-036 SHALL cover: dispatch tags 0,1,2; complete 2 then 1 then 0 -> no retire until tag 0 is done, then three consecutive one-cycle retires in order 0,1,2.
REQ-037 SHALL cover: 8 dispatches without completion -> count=8, disp_ready=0; a 9th offer is ignored; completing the head in a full cycle with disp_valid=1 -> dispatch accepted only after count drops to 7.
REQ-038 SHALL cover: a 20-instruction stream with immediate completion -> tags wrap 7->0 correctly, count stays <=8, 20 retires in order.
REQ-039 SHALL cover: has_dst=0 entry retiring -> commit_valid=1, retire_out[0]=0; completion to a free tag -> no state change.
REQ-040 SHALL cover: rst asserted with 5 entries busy -> next cycle count=0, disp_ready=1 after rst drops, no retire pulse.

Source files
------------

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: entries are allocated at dispatch, marked done on
// completion, and retired one per cycle from the head in dispatch order.
module reorder_buffer #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic             disp_has_dst,
  input  logic [2:0]       disp_areg,
  input  logic [3:0]       disp_preg,
  input  logic [3:0]       disp_old_preg,
  output logic [TAG_W-1:0] disp_tag,
  input  logic             cmpl_valid,
  input  logic [TAG_W-1:0] cmpl_tag,
  output logic [4:0]       retire_out,
  output logic             commit_valid,
  output logic [2:0]       commit_areg,
  output logic [3:0]       commit_preg,
  output logic [TAG_W:0]   count
);
  localparam logic [TAG_W:0] PTR_ONE  = (TAG_W+1)'(1);
  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

  // Pointers carry a wrap bit above the index so full and empty are distinct.
  logic [TAG_W:0] head_q, head_d, tail_q, tail_d, count_q, count_d;

  logic [DEPTH-1:0]      busy_q, busy_d, done_q, done_d, has_dst_q, has_dst_d;
  logic [DEPTH-1:0][2:0] areg_q, areg_d;
  logic [DEPTH-1:0][3:0] preg_q, preg_d, old_preg_q, old_preg_d;

  logic       commit_valid_q, commit_valid_d;
  logic [2:0] commit_areg_q, commit_areg_d;
  logic [3:0] commit_preg_q, commit_preg_d;
  logic [4:0] retire_out_q, retire_out_d;

  logic [TAG_W-1:0] head_idx, tail_idx;
  logic             retire, disp_fire, cmpl_hit;

  assign head_idx   = head_q[TAG_W-1:0];
  assign tail_idx   = tail_q[TAG_W-1:0];
  // A full buffer blocks dispatch even when the head retires this same edge.
  assign disp_ready = !rst && (count_q < FULL_CNT);
  assign disp_tag   = tail_idx;
  assign disp_fire  = disp_valid && disp_ready;
  assign retire     = busy_q[head_idx] && done_q[head_idx];
  assign cmpl_hit   = cmpl_valid && busy_q[cmpl_tag] && !done_q[cmpl_tag];

  always_comb begin
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    busy_d         = busy_q;
    done_d         = done_q;
    has_dst_d      = has_dst_q;
    areg_d         = areg_q;
    preg_d         = preg_q;
    old_preg_d     = old_preg_q;
    commit_valid_d = 1'b0;
    commit_areg_d  = commit_areg_q;
    commit_preg_d  = commit_preg_q;
    retire_out_d   = 5'b0;

    if (rst) begin
      head_d        = '0;
      tail_d        = '0;
      count_d       = '0;
      busy_d        = '0;
      done_d        = '0;
      commit_areg_d = '0;
      commit_preg_d = '0;
    end else begin
      if (cmpl_hit) done_d[cmpl_tag] = 1'b1;

      if (retire) begin
        busy_d[head_idx] = 1'b0;
        done_d[head_idx] = 1'b0;
        head_d           = head_q + PTR_ONE;
        commit_valid_d   = 1'b1;
        commit_areg_d    = areg_q[head_idx];
        commit_preg_d    = preg_q[head_idx];
        retire_out_d     = {old_preg_q[head_idx], has_dst_q[head_idx]};
      end

      // Tail never aliases the retiring head: that would require a full buffer.
      if (disp_fire) begin
        busy_d[tail_idx]     = 1'b1;
        done_d[tail_idx]     = 1'b0;
        has_dst_d[tail_idx]  = disp_has_dst;
        areg_d[tail_idx]     = disp_areg;
        preg_d[tail_idx]     = disp_preg;
        old_preg_d[tail_idx] = disp_old_preg;
        tail_d               = tail_q + PTR_ONE;
      end

      case ({disp_fire, retire})
        2'b10:   count_d = count_q + PTR_ONE;
        2'b01:   count_d = count_q - PTR_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    head_q         <= head_d;
    tail_q         <= tail_d;
    count_q        <= count_d;
    busy_q         <= busy_d;
    done_q         <= done_d;
    has_dst_q      <= has_dst_d;
    areg_q         <= areg_d;
    preg_q         <= preg_d;
    old_preg_q     <= old_preg_d;
    commit_valid_q <= commit_valid_d;
    commit_areg_q  <= commit_areg_d;
    commit_preg_q  <= commit_preg_d;
    retire_out_q   <= retire_out_d;
  end

  assign commit_valid = commit_valid_q;
  assign commit_areg  = commit_areg_q;
  assign commit_preg  = commit_preg_q;
  assign retire_out   = retire_out_q;
  assign count        = count_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: latency, in-order retire, full, wrap, reset.
module tb_reorder_buffer;
  logic       clk = 1'b0;
  logic       rst;
  logic       disp_valid, disp_ready, disp_has_dst;
  logic [2:0] disp_areg;
  logic [3:0] disp_preg, disp_old_preg;
  logic [2:0] disp_tag;
  logic       cmpl_valid;
  logic [2:0] cmpl_tag;
  logic [4:0] retire_out;
  logic       commit_valid;
  logic [2:0] commit_areg;
  logic [3:0] commit_preg;
  logic [3:0] count;

  int n_run = 0;
  int n_fail = 0;

  reorder_buffer #(.DEPTH(8), .TAG_W(3)) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_has_dst(disp_has_dst),
    .disp_areg(disp_areg), .disp_preg(disp_preg), .disp_old_preg(disp_old_preg),
    .disp_tag(disp_tag), .cmpl_valid(cmpl_valid), .cmpl_tag(cmpl_tag),
    .retire_out(retire_out), .commit_valid(commit_valid),
    .commit_areg(commit_areg), .commit_preg(commit_preg), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    disp_valid = 1'b0; disp_has_dst = 1'b0; disp_areg = '0;
    disp_preg = '0; disp_old_preg = '0; cmpl_valid = 1'b0; cmpl_tag = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic dispatch(input int areg, input int preg, input int old, input bit has_dst);
    disp_valid = 1'b1; disp_has_dst = has_dst; disp_areg = 3'(areg);
    disp_preg = 4'(preg); disp_old_preg = 4'(old);
    tick();
    disp_valid = 1'b0;
  endtask

  task automatic complete(input int tag);
    cmpl_valid = 1'b1; cmpl_tag = 3'(tag);
    tick();
    cmpl_valid = 1'b0;
  endtask

  int issued, retired, maxc;
  bit pend;
  logic [2:0] ptag;

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    check("rst_ready_low", int'(disp_ready), 0);
    tick();
    check("rst_count", int'(count), 0);
    check("rst_cvalid", int'(commit_valid), 0);
    check("rst_rout", int'(retire_out), 0);
    check("rst_areg", int'(commit_areg), 0);
    check("rst_preg", int'(commit_preg), 0);
    rst = 1'b0;
    #1;
    check("rst_ready_hi", int'(disp_ready), 1);
    check("rst_tag", int'(disp_tag), 0);

    // Minimum latency: dispatch E0, complete E1, retire visible after E2.
    dispatch(2, 9, 2, 1'b1);
    check("lat_cnt1", int'(count), 1);
    check("lat_cv0", int'(commit_valid), 0);
    complete(0);
    check("lat_cv_e1", int'(commit_valid), 0);
    tick();
    check("lat_cv_e2", int'(commit_valid), 1);
    check("lat_rout", int'(retire_out), 5'b00101);
    check("lat_areg", int'(commit_areg), 2);
    check("lat_preg", int'(commit_preg), 9);
    check("lat_cnt0", int'(count), 0);
    tick();
    check("lat_cv_pulse", int'(commit_valid), 0);
    check("lat_rout_pulse", int'(retire_out), 0);

    // Reverse-order completion still retires 0,1,2 back to back.
    do_reset();
    for (int i = 0; i < 3; i++) dispatch(i, i + 1, i + 8, 1'b1);
    check("ooo_cnt3", int'(count), 3);
    complete(2);
    check("ooo_wait2", int'(commit_valid), 0);
    complete(1);
    check("ooo_wait1", int'(commit_valid), 0);
    complete(0);
    check("ooo_wait0", int'(commit_valid), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ooo_cv", int'(commit_valid), 1);
      check("ooo_areg", int'(commit_areg), i);
      check("ooo_preg", int'(commit_preg), i + 1);
      check("ooo_rout", int'(retire_out), ((i + 8) << 1) | 1);
    end
    tick();
    check("ooo_done_cv", int'(commit_valid), 0);
    check("ooo_done_cnt", int'(count), 0);

    // Fill to full, ignored 9th offer, head retire frees a slot one edge later.
    do_reset();
    for (int i = 0; i < 8; i++) dispatch(i, i, 0, 1'b1);
    check("full_cnt", int'(count), 8);
    check("full_ready", int'(disp_ready), 0);
    dispatch(7, 15, 0, 1'b1);
    check("full_9th_cnt", int'(count), 8);
    check("full_9th_tag", int'(disp_tag), 0);
    disp_valid = 1'b1; disp_preg = 4'd15;
    complete(0);
    disp_valid = 1'b1;
    check("full_e1_cnt", int'(count), 8);
    check("full_e1_cv", int'(commit_valid), 0);
    tick();
    check("full_e2_cnt", int'(count), 7);
    check("full_e2_cv", int'(commit_valid), 1);
    check("full_e2_preg", int'(commit_preg), 0);
    check("full_e2_ready", int'(disp_ready), 1);
    tick();
    disp_valid = 1'b0;
    check("full_e3_cnt", int'(count), 8);
    check("full_e3_ready", int'(disp_ready), 0);

    // 20-instruction stream, each completed the cycle after dispatch.
    do_reset();
    issued = 0; retired = 0; maxc = 0; pend = 1'b0; ptag = '0;
    for (int cyc = 0; cyc < 100 && retired < 20; cyc++) begin
      cmpl_valid = pend; cmpl_tag = ptag;
      pend = 1'b0;
      if (issued < 20 && disp_ready) begin
        disp_valid = 1'b1; disp_has_dst = 1'b1;
        disp_preg = 4'(issued); disp_areg = 3'(issued);
        check("strm_tag", int'(disp_tag), issued % 8);
        ptag = disp_tag; pend = 1'b1;
        issued++;
      end else disp_valid = 1'b0;
      tick();
      if (commit_valid) begin
        check("strm_preg", int'(commit_preg), retired % 16);
        retired++;
      end
      if (int'(count) > maxc) maxc = int'(count);
    end
    idle_inputs();
    check("strm_retired", retired, 20);
    check("strm_maxcnt_le8", int'(maxc <= 8), 1);
    check("strm_cnt_end", int'(count), 0);

    // Completion to a free tag is ignored; has_dst=0 retire clears valid bit.
    do_reset();
    complete(3);
    check("free_cnt", int'(count), 0);
    tick();
    check("free_cv", int'(commit_valid), 0);
    dispatch(5, 7, 11, 1'b0);
    complete(0);
    tick();
    check("nodst_cv", int'(commit_valid), 1);
    check("nodst_rout", int'(retire_out), 11 << 1);
    check("nodst_areg", int'(commit_areg), 5);
    complete(0);
    check("nodst_recmpl_cnt", int'(count), 0);
    tick();
    check("nodst_recmpl_cv", int'(commit_valid), 0);

    // Reset with 5 in flight and a head ready to retire: nothing retires.
    do_reset();
    for (int i = 0; i < 5; i++) dispatch(i, i, i, 1'b1);
    complete(0);
    rst = 1'b1;
    #1;
    check("mrst_ready_low", int'(disp_ready), 0);
    tick();
    check("mrst_cnt", int'(count), 0);
    check("mrst_cv", int'(commit_valid), 0);
    check("mrst_rout", int'(retire_out), 0);
    rst = 1'b0;
    #1;
    check("mrst_ready_hi", int'(disp_ready), 1);
    tick();
    check("mrst_cv_after", int'(commit_valid), 0);
    check("mrst_cnt_after", int'(count), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
